// File: rtl/algo_rgb888_2yuv422.sv
// RGB888 -> BT.601 studio-range YCbCr with 4:2:2 chroma decimation.
// Five register stages: products, partial sums, clamp, pair hold, output.
module algo_rgb888_2yuv422 #(
  parameter int P_CHROMA_AVG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_r_8b,
  input  logic [7:0] i_g_8b,
  input  logic [7:0] i_b_8b,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_data_en,
  output logic [7:0] o_y_8b,
  output logic [7:0] o_c_8b,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_data_en
);

  localparam int CTL_STAGES = 4;
  localparam int DE_BIT     = 2;

  // Control word {data_en, hs, vs}, one entry per stage S1..S4
  logic [2:0]  ctl_q [CTL_STAGES];
  logic [2:0]  ctl_d [CTL_STAGES];
  logic [2:0]  out_ctl_q, out_ctl_d;

  logic [15:0] m_y_r_q, m_y_g_q, m_y_b_q, m_y_r_d, m_y_g_d, m_y_b_d;
  logic [15:0] m_cb_r_q, m_cb_g_q, m_cb_b_q, m_cb_r_d, m_cb_g_d, m_cb_b_d;
  logic [15:0] m_cr_r_q, m_cr_g_q, m_cr_b_q, m_cr_r_d, m_cr_g_d, m_cr_b_d;

  logic [16:0] y_sum_q, cb_pos_q, cb_neg_q, cr_pos_q, cr_neg_q;
  logic [16:0] y_sum_d, cb_pos_d, cb_neg_d, cr_pos_d, cr_neg_d;

  logic [7:0]  y3_q, cb3_q, cr3_q, y3_d, cb3_d, cr3_d;
  logic        phase_q, phase_d;

  logic [7:0]  y4_q, cb4_q, cr4_q, y4_d, cb4_d, cr4_d;
  logic        ph4_q, ph4_d;

  logic [7:0]  y_out_q, c_out_q, cr_hold_q;
  logic [7:0]  y_out_d, c_out_d, cr_hold_d;

  logic        s3_de, s4_de, s4_even, pair_avg;
  logic [7:0]  cb_avg, cr_avg;

  function automatic logic [7:0] clamp8(input logic [16:0] pos, input logic [16:0] neg);
    logic [16:0] diff;
    diff = pos - neg;
    if (neg > pos)
      return 8'd0;
    else if (diff[16])
      return 8'd255;
    else
      return 8'(diff >> 8);
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

  always_comb begin
    ctl_d[0] = {i_data_en, i_hs, i_vs};
    for (int k = 1; k < CTL_STAGES; k++)
      ctl_d[k] = ctl_q[k-1];
    out_ctl_d = ctl_q[CTL_STAGES-1];
  end

  // S1: products
  always_comb begin
    m_y_r_d  = 16'(i_r_8b) * 16'd66;
    m_y_g_d  = 16'(i_g_8b) * 16'd129;
    m_y_b_d  = 16'(i_b_8b) * 16'd25;
    m_cb_r_d = 16'(i_r_8b) * 16'd38;
    m_cb_g_d = 16'(i_g_8b) * 16'd74;
    m_cb_b_d = 16'(i_b_8b) * 16'd112;
    m_cr_r_d = 16'(i_r_8b) * 16'd112;
    m_cr_g_d = 16'(i_g_8b) * 16'd94;
    m_cr_b_d = 16'(i_b_8b) * 16'd18;
  end

  // S2: positive terms carry the offset and rounding constant
  always_comb begin
    y_sum_d  = 17'(m_y_r_q) + 17'(m_y_g_q) + 17'(m_y_b_q) + 17'd4224;
    cb_pos_d = 17'(m_cb_b_q) + 17'd32896;
    cb_neg_d = 17'(m_cb_r_q) + 17'(m_cb_g_q);
    cr_pos_d = 17'(m_cr_r_q) + 17'd32896;
    cr_neg_d = 17'(m_cr_g_q) + 17'(m_cr_b_q);
  end

  // S3: clamp, plus the pair phase of the pixel now in S3
  always_comb begin
    y3_d    = clamp8(y_sum_q, 17'd0);
    cb3_d   = clamp8(cb_pos_q, cb_neg_q);
    cr3_d   = clamp8(cr_pos_q, cr_neg_q);
    s3_de   = ctl_q[2][DE_BIT];
    phase_d = s3_de ? ~phase_q : 1'b0;
  end

  always_comb begin
    y4_d  = y3_q;
    cb4_d = cb3_q;
    cr4_d = cr3_q;
    ph4_d = phase_q;
  end

  // S4 -> S5: an even pixel in S4 pairs with the odd pixel currently in S3
  always_comb begin
    s4_de     = ctl_q[3][DE_BIT];
    s4_even   = s4_de & ~ph4_q;
    pair_avg  = (P_CHROMA_AVG != 0) && s3_de;
    cb_avg    = avg8(cb4_q, cb3_q);
    cr_avg    = avg8(cr4_q, cr3_q);
    cr_hold_d = cr_hold_q;
    y_out_d   = 8'd0;
    c_out_d   = 8'd0;
    if (s4_de) begin
      y_out_d = y4_q;
      if (s4_even) begin
        c_out_d   = pair_avg ? cb_avg : cb4_q;
        cr_hold_d = pair_avg ? cr_avg : cr4_q;
      end else begin
        c_out_d   = cr_hold_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CTL_STAGES; k++)
        ctl_q[k] <= 3'd0;
      out_ctl_q <= 3'd0;
      m_y_r_q   <= 16'd0;
      m_y_g_q   <= 16'd0;
      m_y_b_q   <= 16'd0;
      m_cb_r_q  <= 16'd0;
      m_cb_g_q  <= 16'd0;
      m_cb_b_q  <= 16'd0;
      m_cr_r_q  <= 16'd0;
      m_cr_g_q  <= 16'd0;
      m_cr_b_q  <= 16'd0;
      y_sum_q   <= 17'd0;
      cb_pos_q  <= 17'd0;
      cb_neg_q  <= 17'd0;
      cr_pos_q  <= 17'd0;
      cr_neg_q  <= 17'd0;
      y3_q      <= 8'd0;
      cb3_q     <= 8'd0;
      cr3_q     <= 8'd0;
      phase_q   <= 1'b0;
      y4_q      <= 8'd0;
      cb4_q     <= 8'd0;
      cr4_q     <= 8'd0;
      ph4_q     <= 1'b0;
      y_out_q   <= 8'd0;
      c_out_q   <= 8'd0;
      cr_hold_q <= 8'd0;
    end else begin
      for (int k = 0; k < CTL_STAGES; k++)
        ctl_q[k] <= ctl_d[k];
      out_ctl_q <= out_ctl_d;
      m_y_r_q   <= m_y_r_d;
      m_y_g_q   <= m_y_g_d;
      m_y_b_q   <= m_y_b_d;
      m_cb_r_q  <= m_cb_r_d;
      m_cb_g_q  <= m_cb_g_d;
      m_cb_b_q  <= m_cb_b_d;
      m_cr_r_q  <= m_cr_r_d;
      m_cr_g_q  <= m_cr_g_d;
      m_cr_b_q  <= m_cr_b_d;
      y_sum_q   <= y_sum_d;
      cb_pos_q  <= cb_pos_d;
      cb_neg_q  <= cb_neg_d;
      cr_pos_q  <= cr_pos_d;
      cr_neg_q  <= cr_neg_d;
      y3_q      <= y3_d;
      cb3_q     <= cb3_d;
      cr3_q     <= cr3_d;
      phase_q   <= phase_d;
      y4_q      <= y4_d;
      cb4_q     <= cb4_d;
      cr4_q     <= cr4_d;
      ph4_q     <= ph4_d;
      y_out_q   <= y_out_d;
      c_out_q   <= c_out_d;
      cr_hold_q <= cr_hold_d;
    end
  end

  assign o_y_8b    = y_out_q;
  assign o_c_8b    = c_out_q;
  assign o_data_en = out_ctl_q[2];
  assign o_hs      = out_ctl_q[1];
  assign o_vs      = out_ctl_q[0];

endmodule

// File: tb/tb_algo_rgb888_2yuv422.sv
// Self-checking bench: two instances (averaging / even-pixel chroma) against
// a history-based model of the expected stream, plus hand-computed literals.
module tb_algo_rgb888_2yuv422;

  localparam int N = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic       hs = 1'b0, vs = 1'b0, de = 1'b0;

  logic [7:0] a_y, a_c, n_y, n_c;
  logic       a_hs, a_vs, a_de, n_hs, n_vs, n_de;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Input history, one entry per sampling edge; reset blanks in-flight entries
  logic [7:0] h_r [N];
  logic [7:0] h_g [N];
  logic [7:0] h_b [N];
  logic       h_de [N];
  logic       h_hs [N];
  logic       h_vs [N];

  // Directed sequence tables and captured outputs
  logic [7:0] s_r [16];
  logic [7:0] s_g [16];
  logic [7:0] s_b [16];
  logic       s_de [16];
  int cap_y [32];
  int cap_ca [32];
  int cap_cn [32];
  int cap_de [32];

  always #5 clk = ~clk;

  algo_rgb888_2yuv422 #(.P_CHROMA_AVG(1)) dut_avg (
    .clk(clk), .rst_n(rst_n), .i_r_8b(r), .i_g_8b(g), .i_b_8b(b),
    .i_hs(hs), .i_vs(vs), .i_data_en(de),
    .o_y_8b(a_y), .o_c_8b(a_c), .o_hs(a_hs), .o_vs(a_vs), .o_data_en(a_de)
  );

  algo_rgb888_2yuv422 #(.P_CHROMA_AVG(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .i_r_8b(r), .i_g_8b(g), .i_b_8b(b),
    .i_hs(hs), .i_vs(vs), .i_data_en(de),
    .o_y_8b(n_y), .o_c_8b(n_c), .o_hs(n_hs), .o_vs(n_vs), .o_data_en(n_de)
  );

  always @(posedge clk) begin
    if (cyc < N) begin
      if (!rst_n) begin
        for (int k = 0; k < 7; k++) begin
          if (cyc >= k) begin
            h_de[cyc-k] <= 1'b0;
            h_hs[cyc-k] <= 1'b0;
            h_vs[cyc-k] <= 1'b0;
          end
        end
      end else begin
        h_r[cyc]  <= r;
        h_g[cyc]  <= g;
        h_b[cyc]  <= b;
        h_de[cyc] <= de;
        h_hs[cyc] <= hs;
        h_vs[cyc] <= vs;
      end
    end
    cyc <= cyc + 1;
  end

  function automatic int clampv(int v);
    if (v < 0) return 0;
    if (v >= 65536) return 255;
    return v / 256;
  endfunction

  function automatic int fy(int idx);
    return clampv(66*h_r[idx] + 129*h_g[idx] + 25*h_b[idx] + 4224);
  endfunction

  function automatic int fcb(int idx);
    return clampv(112*h_b[idx] - 38*h_r[idx] - 74*h_g[idx] + 32896);
  endfunction

  function automatic int fcr(int idx);
    return clampv(112*h_r[idx] - 94*h_g[idx] - 18*h_b[idx] + 32896);
  endfunction

  function automatic int avg(int x, int y);
    return (x + y + 1) / 2;
  endfunction

  // Position of pixel idx within its contiguous data_en run
  function automatic int runpos(int idx);
    int p;
    p = 0;
    for (int j = idx - 1; j >= 0; j--) begin
      if (!h_de[j]) break;
      p++;
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    int m, ey, eca, ecn, ede, ehs, evs;
    m = cyc - 5;
    ey = 0; eca = 0; ecn = 0; ede = 0; ehs = 0; evs = 0;
    if (rst_n && m >= 0) begin
      ehs = int'(h_hs[m]);
      evs = int'(h_vs[m]);
      ede = int'(h_de[m]);
      if (h_de[m]) begin
        ey = fy(m);
        if (runpos(m) % 2 == 0) begin
          ecn = fcb(m);
          eca = h_de[m+1] ? avg(fcb(m), fcb(m+1)) : fcb(m);
        end else begin
          ecn = fcr(m-1);
          eca = avg(fcr(m-1), fcr(m));
        end
      end
    end
    chk("model_y_avg", 32'(a_y), 32'(ey));
    chk("model_c_avg", 32'(a_c), 32'(eca));
    chk("model_de_avg", 32'(a_de), 32'(ede));
    chk("model_hs_avg", 32'(a_hs), 32'(ehs));
    chk("model_vs_avg", 32'(a_vs), 32'(evs));
    chk("model_y_even", 32'(n_y), 32'(ey));
    chk("model_c_even", 32'(n_c), 32'(ecn));
    chk("model_de_even", 32'(n_de), 32'(ede));
    chk("model_hs_even", 32'(n_hs), 32'(ehs));
    chk("model_vs_even", 32'(n_vs), 32'(evs));
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                       input logic dd, input logic hh, input logic vv);
    r = rr; g = gg; b = bb; de = dd; hs = hh; vs = vv;
  endtask

  task automatic set_px(input int i, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    s_r[i] = rr; s_g[i] = gg; s_b[i] = bb; s_de[i] = 1'b1;
  endtask

  task automatic set_gap(input int i);
    s_r[i] = 8'd0; s_g[i] = 8'd0; s_b[i] = 8'd0; s_de[i] = 1'b0;
  endtask

  // cap_*[j+5] holds the output produced by table entry j
  task automatic run_seq(input string nm, input int n);
    for (int i = 0; i < n + 6; i++) begin
      step();
      cap_y[i]  = int'(a_y);
      cap_ca[i] = int'(a_c);
      cap_cn[i] = int'(n_c);
      cap_de[i] = int'(a_de);
      if (i < n) drive(s_r[i], s_g[i], s_b[i], s_de[i], 1'b0, 1'b0);
      else       drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    end
    $display("[TB] sequence %s: %0d entries", nm, n);
  endtask

  task automatic chk_pix(input string nm, input int k, input int ey, input int eca, input int ecn);
    chk({nm, "_de"}, 32'(cap_de[k+5]), 32'd1);
    chk({nm, "_y"}, 32'(cap_y[k+5]), 32'(ey));
    chk({nm, "_c_avg"}, 32'(cap_ca[k+5]), 32'(eca));
    chk({nm, "_c_even"}, 32'(cap_cn[k+5]), 32'(ecn));
  endtask

  initial begin
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_y", 32'(a_y), 32'd0);
    chk("rst_c", 32'(a_c), 32'd0);
    chk("rst_de", 32'(a_de), 32'd0);
    chk("rst_hs", 32'(a_hs), 32'd0);
    chk("rst_vs", 32'(a_vs), 32'd0);
    rst_n = 1'b1;

    set_px(0, 8'd255, 8'd255, 8'd255);
    run_seq("white", 1);
    chk("lat_pre_de", 32'(cap_de[4]), 32'd0);
    chk("lat_pre_y", 32'(cap_y[4]), 32'd0);
    chk_pix("white", 0, 235, 128, 128);

    set_px(0, 8'd0, 8'd0, 8'd0); set_px(1, 8'd0, 8'd0, 8'd0);
    run_seq("black", 2);
    chk_pix("black0", 0, 16, 128, 128);
    chk_pix("black1", 1, 16, 128, 128);

    set_px(0, 8'd255, 8'd0, 8'd0); set_px(1, 8'd255, 8'd0, 8'd0);
    run_seq("red", 2);
    chk_pix("red0", 0, 82, 90, 90);
    chk_pix("red1", 1, 82, 240, 240);

    set_px(0, 8'd0, 8'd0, 8'd255); set_px(1, 8'd0, 8'd0, 8'd255);
    run_seq("blue", 2);
    chk_pix("blue0", 0, 41, 240, 240);
    chk_pix("blue1", 1, 41, 110, 110);

    set_px(0, 8'd255, 8'd0, 8'd0); set_px(1, 8'd0, 8'd0, 8'd255);
    run_seq("red_blue", 2);
    chk_pix("rb0", 0, 82, 165, 90);
    chk_pix("rb1", 1, 41, 175, 240);

    set_px(0, 8'd255, 8'd0, 8'd0); set_px(1, 8'd255, 8'd0, 8'd0);
    set_px(2, 8'd255, 8'd0, 8'd0); set_gap(3); set_px(4, 8'd0, 8'd0, 8'd255);
    run_seq("odd_line", 5);
    chk_pix("odd0", 0, 82, 90, 90);
    chk_pix("odd1", 1, 82, 240, 240);
    chk_pix("odd2", 2, 82, 90, 90);
    chk("odd_gap_de", 32'(cap_de[8]), 32'd0);
    chk("odd_gap_c", 32'(cap_ca[8]), 32'd0);
    chk_pix("next_line", 4, 41, 240, 240);

    // Odd-length run interrupted by an asynchronous reset between edges
    for (int i = 0; i < 7; i++) begin
      step();
      drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2;
    chk("pre_arst_de", 32'(a_de), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(a_y), 32'd0);
    chk("arst_c", 32'(a_c), 32'd0);
    chk("arst_de", 32'(a_de), 32'd0);
    chk("arst_c_even", 32'(n_c), 32'd0);
    chk("arst_de_even", 32'(n_de), 32'd0);
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    set_px(0, 8'd0, 8'd0, 8'd255); set_px(1, 8'd255, 8'd0, 8'd0);
    run_seq("after_arst", 2);
    chk_pix("arst_pix0", 0, 41, 165, 240);
    chk_pix("arst_pix1", 1, 82, 175, 110);

    // Random pixels, syncs and data_en gaps, with one reset pulse
    for (int i = 0; i < 2500; i++) begin
      step();
      if (i == 1200) rst_n = 1'b0;
      if (i == 1203) rst_n = 1'b1;
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();
    $display("[TB] random section: 2500 cycles");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
